// File: rtl/demux_param_pkg.sv
// Shared constants and FSM state encoding for the 1-to-2 packet demultiplexer.
package demux_param_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE1 = 2'd1,
    ROUTE2 = 2'd2
  } state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register stage; loads only when free_c_o is high.
module demux_out_slot
  import demux_param_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         free_c_o,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         last_o
);

  logic         valid_q;
  logic [N-1:0] data_q;
  logic         last_q;

  // Slot can take a beat if empty or its held beat leaves this cycle.
  assign free_c_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/demux_param_stream.sv
// Registered 1-to-2 packet demultiplexer: destination picked on a packet's first beat.
// Define DEMUX_CNT_EN to add saturating per-port accepted-beat counters (cnt1/cnt2).
module demux_param_stream
  import demux_param_pkg::*;
#(
  parameter int unsigned N     = N_DEF
`ifdef DEMUX_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [N-1:0]     out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out2_data,
  output logic             out2_last,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);

  state_e state_q;
  logic   dest2_c;
  logic   free1_c;
  logic   free2_c;
  logic   accept_c;
  logic   load1_c;
  logic   load2_c;

  // Destination is live in_sel only between packets; locked otherwise.
  always_comb begin
    dest2_c = 1'b0;
    case (state_q)
      IDLE:    dest2_c = in_sel;
      ROUTE1:  dest2_c = 1'b0;
      ROUTE2:  dest2_c = 1'b1;
      default: dest2_c = 1'b0;
    endcase
  end

  assign in_ready = rst_n && (dest2_c ? free2_c : free1_c);
  assign accept_c = in_valid && in_ready;
  assign load1_c  = accept_c && !dest2_c;
  assign load2_c  = accept_c && dest2_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (accept_c) begin
      if (in_last) begin
        state_q <= IDLE;
      end else begin
        state_q <= dest2_c ? ROUTE2 : ROUTE1;
      end
    end
  end

  demux_out_slot #(.N(N)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load1_c),
    .data_i   (in_data),
    .last_i   (in_last),
    .ready_i  (out1_ready),
    .free_c_o (free1_c),
    .valid_o  (out1_valid),
    .data_o   (out1_data),
    .last_o   (out1_last)
  );

  demux_out_slot #(.N(N)) u_slot2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load2_c),
    .data_i   (in_data),
    .last_i   (in_last),
    .ready_i  (out2_ready),
    .free_c_o (free2_c),
    .valid_o  (out2_valid),
    .data_o   (out2_data),
    .last_o   (out2_last)
  );

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt2_q;

  // Saturating counters: stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (load1_c && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
      if (load2_c && (cnt2_q != {CNT_W{1'b1}})) cnt2_q <= cnt2_q + CNT_W'(1);
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`endif

endmodule
